// File: rtl/status_event_capture.sv
// status_event_capture
//   Conditions raw hardware status nets before they reach the UDB status
//   register. Each input is synchronized, then either passed through as a
//   level or captured as a sticky rising edge. Sticky bits also track
//   overrun (a second edge before firmware read the first). A registered,
//   masked OR of the conditioned status drives the interrupt.
//
// Ports
//   clock       single clock for all state
//   reset       synchronous, active-high
//   status_in   [7:0] raw status nets
//   read_clear  one-cycle firmware read strobe; clears sticky and overrun bits
//   status_out  [7:0] conditioned status to the status register
//   overrun     [7:0] per sticky bit: new edge while the bit was already set
//   intr        registered OR of (status_out & IntMask), active bits only
module status_event_capture #(
  parameter int         NumInputs  = 8,
  parameter int         SyncStages = 2,
  parameter logic [7:0] StickyMask = 8'h00,
  parameter logic [7:0] IntMask    = 8'h7F
) (
  input  logic       clock,
  input  logic       reset,
  input  logic [7:0] status_in,
  input  logic       read_clear,
  output logic [7:0] status_out,
  output logic [7:0] overrun,
  output logic       intr
);

  function automatic logic [7:0] active_mask_f();
    logic [7:0] m;
    m = '0;
    for (int i = 0; i < 8; i++) begin
      m[i] = (i < NumInputs);
    end
    return m;
  endfunction

  localparam logic [7:0] ActiveMask = active_mask_f();
  localparam logic [7:0] StickyAct  = StickyMask & ActiveMask;
  localparam logic [7:0] IntAct     = IntMask & ActiveMask;
  localparam logic [1:0] ArmCount   = 2'(SyncStages + 1);

  logic [7:0] s;
  logic [7:0] s_d;
  logic [1:0] arm_cnt;
  logic       armed;
  logic [7:0] edge_det;
  logic [7:0] next_status;
  logic [7:0] next_overrun;

  // Inactive bits are masked before the first flop so their synchronizer
  // collapses to constants.
  generate
    if (SyncStages == 0) begin : g_sync0
      assign s = status_in & ActiveMask;
    end else if (SyncStages == 1) begin : g_sync1
      logic [7:0] sync_q;
      always_ff @(posedge clock) begin
        if (reset) sync_q <= '0;
        else       sync_q <= status_in & ActiveMask;
      end
      assign s = sync_q;
    end else begin : g_sync2
      logic [7:0] sync_q1;
      logic [7:0] sync_q2;
      always_ff @(posedge clock) begin
        if (reset) begin
          sync_q1 <= '0;
          sync_q2 <= '0;
        end else begin
          sync_q1 <= status_in & ActiveMask;
          sync_q2 <= sync_q1;
        end
      end
      assign s = sync_q2;
    end
  endgenerate

  // Edges are ignored until the synchronizer pipeline and s_d have filled
  // with real input values, so inputs already high at reset exit do not
  // look like fresh rising edges.
  assign armed = (arm_cnt == ArmCount);

  always_ff @(posedge clock) begin
    if (reset)       arm_cnt <= '0;
    else if (!armed) arm_cnt <= arm_cnt + 2'd1;
  end

  always_comb begin
    edge_det     = s & ~s_d & {8{armed}};
    // Sticky: a new edge beats read_clear; level: follow s.
    next_status  = (StickyMask & (edge_det | (status_out & ~{8{read_clear}})))
                 | (~StickyMask & s);
    next_status  = next_status & ActiveMask;
    next_overrun = '0;
    if (!read_clear) begin
      next_overrun = (overrun | (edge_det & status_out)) & StickyAct;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      s_d        <= '0;
      status_out <= '0;
      overrun    <= '0;
      intr       <= 1'b0;
    end else begin
      s_d        <= s;
      status_out <= next_status;
      overrun    <= next_overrun;
      intr       <= |(next_status & IntAct);
    end
  end

endmodule
